// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared types and constants for the sort chain feeder
package sort_pkg;

    localparam int SORT_DATA_W = 8;
    localparam logic [SORT_DATA_W-1:0] SORT_SENTINEL = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_FLUSH,
        S_DONE
    } feeder_state_t;

endpackage

// File: rtl/sort_feeder.sv
// rtl/sort_feeder.sv - frame input stage for the SortCell chain: clear, load, sentinel flush
// Optional dropped-word counter output ovf_words enabled by SORT_FEEDER_OVF_CNT_EN.
module sort_feeder
    import sort_pkg::*;
#(
    parameter int DATA_W = SORT_DATA_W,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_last,
    output logic                       cell_en,
    output logic [DATA_W-1:0]          cell_data,
    output logic                       cell_clear,
    output logic                       cell_flush,
`ifdef SORT_FEEDER_OVF_CNT_EN
    output logic [15:0]                ovf_words,
`endif
    output logic [$clog2(DEPTH+1)-1:0] frame_len,
    output logic                       frame_ovf,
    output logic                       frame_done
);

    localparam int LW = $clog2(DEPTH+1);
    localparam int FW = $clog2(DEPTH);
    localparam logic [LW-1:0]     DEPTH_L = LW'(DEPTH);
    localparam logic [FW-1:0]     FLUSH_LAST = FW'(DEPTH-1);
    localparam logic [DATA_W-1:0] SENT = {DATA_W{SORT_SENTINEL[0]}};

    feeder_state_t     state, state_d;
    logic [LW-1:0]     cnt, cnt_d, len_d;
    logic [FW-1:0]     fcnt, fcnt_d;
    logic              ovf, ovf_d, last_q, last_d, fovf_d;
    logic [DATA_W-1:0] word_q, word_d, data_d;
    logic              ready_d, en_d, clear_d, flush_d, done_d;
    logic              hs;

    assign hs = in_valid && in_ready;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        fcnt_d  = fcnt;
        ovf_d   = ovf;
        last_d  = last_q;
        word_d  = word_q;
        data_d  = cell_data;
        en_d    = 1'b0;
        clear_d = 1'b0;
        flush_d = 1'b0;
        done_d  = 1'b0;
        len_d   = frame_len;
        fovf_d  = frame_ovf;
        case (state)
            S_IDLE: begin
                if (hs) begin
                    state_d = S_CLEAR;
                    word_d  = in_data;
                    last_d  = in_last;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    clear_d = 1'b1;
                end
            end
            S_CLEAR: begin
                // The word captured in IDLE goes out right after the clear pulse.
                en_d   = 1'b1;
                data_d = word_q;
                cnt_d  = LW'(1);
                if (last_q) begin
                    state_d = S_FLUSH;
                    fcnt_d  = FLUSH_LAST;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (hs) begin
                    if (cnt < DEPTH_L) begin
                        en_d   = 1'b1;
                        data_d = in_data;
                        cnt_d  = cnt + LW'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (in_last) begin
                        state_d = S_FLUSH;
                        fcnt_d  = FLUSH_LAST;
                    end
                end
            end
            S_FLUSH: begin
                en_d    = 1'b1;
                flush_d = 1'b1;
                data_d  = SENT;
                if (fcnt == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    len_d   = cnt;
                    fovf_d  = ovf;
                end else begin
                    fcnt_d = fcnt - FW'(1);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            fcnt       <= '0;
            ovf        <= 1'b0;
            last_q     <= 1'b0;
            word_q     <= '0;
            in_ready   <= 1'b0;
            cell_en    <= 1'b0;
            cell_data  <= '0;
            cell_clear <= 1'b0;
            cell_flush <= 1'b0;
            frame_len  <= '0;
            frame_ovf  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            fcnt       <= fcnt_d;
            ovf        <= ovf_d;
            last_q     <= last_d;
            word_q     <= word_d;
            in_ready   <= ready_d;
            cell_en    <= en_d;
            cell_data  <= data_d;
            cell_clear <= clear_d;
            cell_flush <= flush_d;
            frame_len  <= len_d;
            frame_ovf  <= fovf_d;
            frame_done <= done_d;
        end
    end

`ifdef SORT_FEEDER_OVF_CNT_EN
    logic drop;
    assign drop = (state == S_LOAD) && hs && (cnt == DEPTH_L);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_words <= '0;
        end else if (drop && (ovf_words != 16'hFFFF)) begin
            ovf_words <= ovf_words + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sort_feeder.sv
// tb/tb_sort_feeder.sv - directed self-checking bench for sort_feeder
module tb_sort_feeder;

    localparam int DW = 8;
    localparam int D  = 8;
    localparam int LW = $clog2(D+1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          cell_en, cell_clear, cell_flush;
    logic [DW-1:0] cell_data;
    logic [LW-1:0] frame_len;
    logic          frame_ovf, frame_done;
`ifdef SORT_FEEDER_OVF_CNT_EN
    logic [15:0]   ovf_words;
`endif

    sort_feeder #(.DATA_W(DW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .cell_en(cell_en), .cell_data(cell_data), .cell_clear(cell_clear), .cell_flush(cell_flush),
`ifdef SORT_FEEDER_OVF_CNT_EN
        .ovf_words(ovf_words),
`endif
        .frame_len(frame_len), .frame_ovf(frame_ovf), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    int            hs_q[$];
    int            en_cyc[$];
    logic [DW-1:0] en_dat[$];
    bit            en_fl[$];
    int            done_cyc[$];
    int            done_len[$];
    bit            done_ovf[$];
    int            clr_n;
    int            clr_cyc;

    // Handshakes are taken from pre-edge values; cyc of the handshake is the cycle it completed in.
    always @(posedge clk) begin
        if (in_valid && in_ready) hs_q.push_back(cyc);
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (cell_en) begin
                en_cyc.push_back(cyc);
                en_dat.push_back(cell_data);
                en_fl.push_back(cell_flush);
            end
            if (cell_clear) begin
                clr_n++;
                clr_cyc = cyc;
            end
            if (frame_done) begin
                done_cyc.push_back(cyc);
                done_len.push_back(int'(frame_len));
                done_ovf.push_back(frame_ovf);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got no end want finish");
        $fatal(1);
    end

    task automatic clear_rec();
        hs_q.delete(); en_cyc.delete(); en_dat.delete(); en_fl.delete();
        done_cyc.delete(); done_len.delete(); done_ovf.delete();
        clr_n = 0; clr_cyc = -1;
    endtask

    // Called at a negedge; returns at the negedge following the handshake.
    task automatic send(input logic [DW-1:0] d, input bit l, input int gap, output bit ok);
        int n;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = l;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_done(input int want, output bit ok);
        int n = 0;
        while (done_cyc.size() < want && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = (done_cyc.size() >= want);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if ({in_ready, cell_en, cell_clear, cell_flush, frame_ovf, frame_done} !== 6'b0)
            $display("FAIL reset_flags got %b want 000000", {in_ready, cell_en, cell_clear, cell_flush, frame_ovf, frame_done}); else passed++;
        total++; if (cell_data !== 8'h00) $display("FAIL reset_data got %h want 00", cell_data); else passed++;
        total++; if (frame_len !== 4'd0) $display("FAIL reset_len got %0d want 0", frame_len); else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) $display("FAIL idle_ready got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_frame8();
        logic [DW-1:0] w [8] = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd7, 8'd2, 8'd8, 8'd4};
        bit ok, all_ok = 1'b1;
        clear_rec();
        for (int i = 0; i < 8; i++) begin
            send(w[i], i == 7, 0, ok);
            all_ok &= ok;
        end
        wait_done(1, ok);
        total++; if (!(all_ok && ok)) $display("FAIL f8_timeout got ready=%b done=%b want 1 1", all_ok, ok); else passed++;
        total++; if (clr_n !== 1) $display("FAIL f8_clear_count got %0d want 1", clr_n); else passed++;
        total++; if (en_dat.size() !== 16 || hs_q.size() !== 8)
            $display("FAIL f8_sizes got en=%0d hs=%0d want 16 8", en_dat.size(), hs_q.size()); else passed++;
        if (hs_q.size() == 8) begin
            total++; if (clr_cyc !== hs_q[0] + 1) $display("FAIL f8_clear_cycle got %0d want %0d", clr_cyc, hs_q[0] + 1); else passed++;
            for (int i = 0; i < 16 && i < en_dat.size(); i++) begin
                total++;
                if (en_dat[i] !== (i < 8 ? w[i] : 8'hFF) || en_fl[i] !== (i >= 8) ||
                    en_cyc[i] !== (i < 8 ? hs_q[i] + (i == 0 ? 2 : 1) : hs_q[7] + 1 + (i - 7)))
                    $display("FAIL f8_word%0d got %h/%b@%0d want %h/%b@%0d", i, en_dat[i], en_fl[i], en_cyc[i],
                             (i < 8 ? w[i] : 8'hFF), (i >= 8), (i < 8 ? hs_q[i] + (i == 0 ? 2 : 1) : hs_q[7] + 1 + (i - 7)));
                else passed++;
            end
            total++; if (done_cyc.size() < 1 || done_cyc[0] !== hs_q[7] + D + 1)
                $display("FAIL f8_done_cycle got %0d want %0d", done_cyc.size() ? done_cyc[0] : -1, hs_q[7] + D + 1); else passed++;
        end
        total++; if (done_len.size() < 1 || done_len[0] !== 8 || done_ovf[0] !== 1'b0)
            $display("FAIL f8_len_ovf got %0d/%b want 8/0", done_len.size() ? done_len[0] : -1, done_ovf.size() ? done_ovf[0] : 1'bx); else passed++;
        total++; if (frame_len !== 4'd8) $display("FAIL f8_len_hold got %0d want 8", frame_len); else passed++;
    endtask

    task automatic test_single();
        bit ok, ok2;
        clear_rec();
        send(8'h42, 1'b1, 0, ok);
        wait_done(1, ok2);
        total++; if (!(ok && ok2)) $display("FAIL single_timeout got %b %b want 1 1", ok, ok2); else passed++;
        total++; if (en_dat.size() !== 9 || hs_q.size() !== 1 || clr_n !== 1)
            $display("FAIL single_sizes got en=%0d hs=%0d clr=%0d want 9 1 1", en_dat.size(), hs_q.size(), clr_n); else passed++;
        if (en_dat.size() == 9 && hs_q.size() == 1) begin
            total++; if (clr_cyc !== hs_q[0] + 1) $display("FAIL single_clear_cycle got %0d want %0d", clr_cyc, hs_q[0] + 1); else passed++;
            for (int i = 0; i < 9; i++) begin
                total++;
                if (en_dat[i] !== (i == 0 ? 8'h42 : 8'hFF) || en_fl[i] !== (i != 0) || en_cyc[i] !== hs_q[0] + 2 + i)
                    $display("FAIL single_word%0d got %h/%b@%0d want %h/%b@%0d", i, en_dat[i], en_fl[i], en_cyc[i],
                             (i == 0 ? 8'h42 : 8'hFF), (i != 0), hs_q[0] + 2 + i);
                else passed++;
            end
        end
        total++; if (done_len.size() < 1 || done_len[0] !== 1 || done_ovf[0] !== 1'b0)
            $display("FAIL single_len_ovf got %0d want 1/0", done_len.size() ? done_len[0] : -1); else passed++;
    endtask

    task automatic test_overflow();
        bit ok, all_ok = 1'b1;
        clear_rec();
        for (int i = 0; i < 11; i++) begin
            send(DW'(8'h10 + i), i == 10, 0, ok);
            all_ok &= ok;
        end
        wait_done(1, ok);
        total++; if (!(all_ok && ok)) $display("FAIL ovf_timeout got %b %b want 1 1", all_ok, ok); else passed++;
        total++; if (en_dat.size() !== 16 || hs_q.size() !== 11)
            $display("FAIL ovf_sizes got en=%0d hs=%0d want 16 11", en_dat.size(), hs_q.size()); else passed++;
        if (en_dat.size() == 16 && hs_q.size() == 11) begin
            for (int i = 0; i < 16; i++) begin
                total++;
                if (en_dat[i] !== (i < 8 ? DW'(8'h10 + i) : 8'hFF) || en_fl[i] !== (i >= 8))
                    $display("FAIL ovf_word%0d got %h/%b want %h/%b", i, en_dat[i], en_fl[i], (i < 8 ? DW'(8'h10 + i) : 8'hFF), (i >= 8));
                else passed++;
            end
            total++; if (en_cyc[8] !== hs_q[10] + 2) $display("FAIL ovf_first_sentinel got %0d want %0d", en_cyc[8], hs_q[10] + 2); else passed++;
        end
        total++; if (done_len.size() < 1 || done_len[0] !== 8 || done_ovf[0] !== 1'b1)
            $display("FAIL ovf_len_ovf got %0d/%b want 8/1", done_len.size() ? done_len[0] : -1, done_ovf.size() ? done_ovf[0] : 1'bx); else passed++;
`ifdef SORT_FEEDER_OVF_CNT_EN
        total++; if (ovf_words !== 16'd3) $display("FAIL ovf_words got %0d want 3", ovf_words); else passed++;
`endif
    endtask

    task automatic test_gaps();
        logic [DW-1:0] w [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        int gap [6] = '{0, 2, 0, 1, 3, 0};
        bit ok, all_ok = 1'b1;
        clear_rec();
        for (int i = 0; i < 6; i++) begin
            send(w[i], i == 5, gap[i], ok);
            all_ok &= ok;
        end
        wait_done(1, ok);
        total++; if (!(all_ok && ok)) $display("FAIL gap_timeout got %b %b want 1 1", all_ok, ok); else passed++;
        total++; if (en_dat.size() !== 14 || hs_q.size() !== 6)
            $display("FAIL gap_sizes got en=%0d hs=%0d want 14 6", en_dat.size(), hs_q.size()); else passed++;
        if (en_dat.size() == 14 && hs_q.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (en_dat[i] !== w[i] || en_cyc[i] !== hs_q[i] + (i == 0 ? 2 : 1))
                    $display("FAIL gap_word%0d got %h@%0d want %h@%0d", i, en_dat[i], en_cyc[i], w[i], hs_q[i] + (i == 0 ? 2 : 1));
                else passed++;
            end
            total++; if (en_cyc[6] !== hs_q[5] + 2 || en_fl[6] !== 1'b1)
                $display("FAIL gap_first_sentinel got %0d/%b want %0d/1", en_cyc[6], en_fl[6], hs_q[5] + 2); else passed++;
        end
        total++; if (done_len.size() < 1 || done_len[0] !== 6)
            $display("FAIL gap_len got %0d want 6", done_len.size() ? done_len[0] : -1); else passed++;
    endtask

    task automatic test_reset_flush();
        bit ok, ok2, ok3;
        int n = 0;
        clear_rec();
        send(8'h01, 1'b0, 0, ok);
        send(8'h02, 1'b1, 0, ok2);
        while (en_dat.size() < 5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++; if (!(ok && ok2 && en_dat.size() >= 5)) $display("FAIL rf_reach_flush got %0d want 5", en_dat.size()); else passed++;
        rst = 1'b1;
        #1;
        total++; if ({in_ready, cell_en, cell_clear, cell_flush, frame_ovf, frame_done} !== 6'b0 || cell_data !== 8'h00 || frame_len !== 4'd0)
            $display("FAIL rf_async_zero got %b %h %0d want 000000 00 0",
                     {in_ready, cell_en, cell_clear, cell_flush, frame_ovf, frame_done}, cell_data, frame_len); else passed++;
`ifdef SORT_FEEDER_OVF_CNT_EN
        total++; if (ovf_words !== 16'd0) $display("FAIL rf_ovf_words got %0d want 0", ovf_words); else passed++;
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_rec();
        send(8'h30, 1'b0, 0, ok);
        send(8'h31, 1'b1, 0, ok2);
        wait_done(1, ok3);
        total++; if (!(ok && ok2 && ok3)) $display("FAIL rf_timeout got %b%b%b want 111", ok, ok2, ok3); else passed++;
        total++; if (en_dat.size() !== 10 || en_dat[0] !== 8'h30 || en_dat[1] !== 8'h31 || clr_n !== 1)
            $display("FAIL rf_new_frame got n=%0d %h %h clr=%0d want 10 30 31 1", en_dat.size(), en_dat[0], en_dat[1], clr_n); else passed++;
        total++; if (done_len.size() < 1 || done_len[0] !== 2 || done_ovf[0] !== 1'b0)
            $display("FAIL rf_len got %0d want 2", done_len.size() ? done_len[0] : -1); else passed++;
    endtask

    task automatic test_back_to_back();
        bit ok, all_ok = 1'b1;
        clear_rec();
        for (int i = 0; i < 8; i++) begin
            send(DW'(8'hA0 + i), (i % 4) == 3, 0, ok);
            all_ok &= ok;
        end
        wait_done(2, ok);
        total++; if (!(all_ok && ok)) $display("FAIL b2b_timeout got %b %b want 1 1", all_ok, ok); else passed++;
        total++; if (hs_q.size() !== 8 || done_cyc.size() !== 2 || clr_n !== 2 || en_dat.size() !== 24)
            $display("FAIL b2b_sizes got hs=%0d done=%0d clr=%0d en=%0d want 8 2 2 24",
                     hs_q.size(), done_cyc.size(), clr_n, en_dat.size()); else passed++;
        if (hs_q.size() == 8 && done_cyc.size() == 2) begin
            total++; if (hs_q[4] !== done_cyc[0] + 1) $display("FAIL b2b_next_hs got %0d want %0d", hs_q[4], done_cyc[0] + 1); else passed++;
            total++; if (done_len[0] !== 4 || done_len[1] !== 4)
                $display("FAIL b2b_len got %0d %0d want 4 4", done_len[0], done_len[1]); else passed++;
            total++; if (done_cyc[1] !== hs_q[7] + D + 1) $display("FAIL b2b_done2 got %0d want %0d", done_cyc[1], hs_q[7] + D + 1); else passed++;
        end
        if (en_dat.size() == 24) begin
            total++; if (en_dat[12] !== 8'hA4 || en_fl[12] !== 1'b0)
                $display("FAIL b2b_second_first got %h/%b want a4/0", en_dat[12], en_fl[12]); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_frame8();
        test_single();
        test_overflow();
        test_gaps();
        test_reset_flush();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sort_feeder.md
# sort_feeder

Frame-level input stage that sits directly upstream of the systolic `SortCell` chain. It accepts words over a valid/ready stream, presents one word per cycle to the first cell's serial input, and brackets each frame with a clear pulse. After the frame's last word it injects DEPTH all-ones sentinel words to push the sorted contents out of the chain. It also tracks frame length and flags frames longer than the chain.

## Interface
- `DATA_W`, default 8: word width; must match the `SortCell` storage width.
- `DEPTH`, default 8: number of cells in the chain, which is also the maximum frame length; must be ≥ 2.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: upstream word valid.
- `in_ready`, output, 1: feeder can accept a word this cycle.
- `in_data`, input, DATA_W: upstream word.
- `in_last`, input, 1: qualifies the final word of a frame.
- `cell_en`, output, 1: chain shift enable; `cell_data` is valid.
- `cell_data`, output, DATA_W: serial word to the first cell.
- `cell_clear`, output, 1: one-cycle pulse that resets all cell storage to the all-ones value.
- `cell_flush`, output, 1: the current `cell_data` is a sentinel.
- `frame_len`, output, $clog2(DEPTH+1): number of words kept in the last completed frame.
- `frame_ovf`, output, 1: the last completed frame exceeded DEPTH words.
- `frame_done`, output, 1: one-cycle pulse at the end of the flush.

## Operation
- FSM states: IDLE, CLEAR, LOAD, FLUSH, DONE.
- IDLE:
  - `in_ready`=1.
  - On the first handshake, go to CLEAR, capture the word, and clear `cnt`, `ovf` and the sticky last flag.
- CLEAR:
  - `cell_clear`=1 for one cycle.
  - `in_ready`=0.
  - Go to LOAD, or straight to FLUSH if the captured word had `in_last`.
- LOAD:
  - `in_ready`=1.
  - Each handshake with `cnt` < DEPTH presents the word next cycle with `cell_en`=1 and increments `cnt`.
  - A handshake with `cnt` == DEPTH drops the word, sets `ovf`, and leaves `cell_en`=0.
  - A handshake with `in_last` goes to FLUSH.
- The first captured word is presented in the cycle after CLEAR, so `cnt` counts it.
- FLUSH:
  - `in_ready`=0.
  - Drive DEPTH consecutive cycles with `cell_en`=1, `cell_flush`=1 and `cell_data`={DATA_W{1'b1}}.
  - A down-counter tracks the DEPTH cycles.
- DONE:
  - `frame_done`=1 for one cycle.
  - `frame_len` and `frame_ovf` update in this cycle and hold until the next DONE.
  - Go to IDLE.
- Gaps with `in_valid`=0 in LOAD produce `cell_en`=0 cycles; the chain holds its state.
- A frame of length 1 is legal (IDLE → CLEAR → FLUSH).
- `in_last` in IDLE followed by a single word is also legal.
- Reset mid-frame abandons the frame. The next frame's CLEAR restores the chain.

## Timing
- Reset values:
  - `in_ready`=0 during reset, 1 in the first cycle after release (IDLE).
  - `cell_en`=0, `cell_data`=0, `cell_clear`=0, `cell_flush`=0.
  - `frame_len`=0, `frame_ovf`=0, `frame_done`=0.
  - State is IDLE.
- All chain-side outputs are registered. An accepted word appears on `cell_data` exactly one cycle after its handshake.
- The first word has two cycles of latency: handshake, then CLEAR, then presented.
- `in_ready` is registered from state only and never depends on `in_valid` in the same cycle.
- The first sentinel follows the last data word in the next cycle with no bubble, unless `in_valid` gaps occurred.
- `frame_done` is asserted DEPTH+1 cycles after the cycle in which the last handshake occurs.
- Back-to-back frames: the handshake of the next frame is possible in the cycle after DONE.

## Configuration
- `SORT_FEEDER_OVF_CNT_EN` defined:
  - Adds output `ovf_words`, 16 bits: a saturating count of dropped words since reset.
  - Cleared only by `rst`.
  - Saturates at 16'hFFFF.
- `SORT_FEEDER_OVF_CNT_EN` undefined: the port and counter are absent. `frame_ovf` behaviour is unchanged.

## Structure
- Shared package `sort_pkg`:
  - State enum `feeder_state_t`.
  - `SORT_DATA_W` default.
  - Sentinel constant `SORT_SENTINEL` = all-ones.
- No sub-module is needed. The FSM, word counter and flush counter live in `sort_feeder`.
- The chain of `SortCell` instances is instantiated by the parent and driven by `cell_en`/`cell_data`.

## Test plan
- Reset, then an 8-word frame 5,3,9,1,7,2,8,4 with `in_last` on 4:
  - `cell_clear` pulses once.
  - The 8 words appear in order, one cycle after each handshake.
  - 8 sentinel cycles of 8'hFF follow.
  - `frame_done` asserts with `frame_len`=8 and `frame_ovf`=0.
- 1-word frame 0x42 with `in_last`:
  - Sequence is CLEAR, then 0x42, then 8 sentinels.
  - `frame_len`=1.
- 11-word frame:
  - Words 9–11 are dropped.
  - `frame_len`=8 and `frame_ovf`=1.
  - With the macro defined, `ovf_words`=3.
- Random `in_valid` gaps in a 6-word frame: `cell_en` gaps match the input gaps, data order is preserved, and `frame_len`=6.
- Assert `rst` during FLUSH, 3 sentinels in:
  - All outputs are 0 immediately.
  - After release, a new 2-word frame completes normally with `frame_len`=2.
- Back-to-back 4-word frames: the second handshake occurs in the cycle after `frame_done`, and each frame reports `frame_len`=4.
